// File: rtl/cartoon_pkg.sv
// rtl/cartoon_pkg.sv - shared pixel and 3x3 window types for the filter path
package cartoon_pkg;

    localparam int PIX_W = 24;
    localparam int WIN_W = 9 * PIX_W;

    typedef logic [PIX_W-1:0] rgb_t;
    typedef logic [WIN_W-1:0] win_t;

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one-line pixel store, shared read/write address, read-old-data
module line_buffer
    import cartoon_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  rgb_t          wdata,
    output rgb_t          rdata
);

    rgb_t mem [DEPTH];

    // Asynchronous read sees the value from before this cycle's write.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_builder.sv
// rtl/window_builder.sv - raster stream to 3x3 RGB window builder for interior pixels
module window_builder
    import cartoon_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIX_W-1:0]         in_pixel,
    input  logic                     in_sof,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIN_W-1:0]         pixelData,
    output logic [$clog2(IMG_W)-1:0] out_x,
    output logic [$clog2(IMG_H)-1:0] out_y,
    output logic                     frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] X_LAST   = CW'(IMG_W - 2);
    localparam logic [RW-1:0] Y_LAST   = RW'(IMG_H - 2);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    rgb_t          win_q [3][3];
    rgb_t          win_d [3][3];
    logic          out_valid_q, out_valid_d;
    win_t          pixel_data_q, pixel_data_d;
    logic [CW-1:0] out_x_q, out_x_d;
    logic [RW-1:0] out_y_q, out_y_d;
    logic          frame_done_q, frame_done_d;

    logic          accept;
    logic          win_hit;
    rgb_t          lb0_rd, lb1_rd;

    assign in_ready = !out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    // A start-of-frame pixel is placed at (0,0) regardless of the running counters.
    assign cur_col = in_sof ? '0 : col_q;
    assign cur_row = in_sof ? '0 : row_q;
    assign win_hit = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

    line_buffer #(.DEPTH(IMG_W), .AW(CW)) lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (cur_col),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .AW(CW)) lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (cur_col),
        .wdata (in_pixel),
        .rdata (lb1_rd)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        out_valid_d  = out_valid_q;
        pixel_data_d = pixel_data_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        frame_done_d = out_valid_q & out_ready & (out_x_q == X_LAST) & (out_y_q == Y_LAST);

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb0_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = in_pixel;

            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end

            // Column >= 2 also guarantees no window straddles a line wrap.
            if (win_hit) begin
                out_valid_d  = 1'b1;
                pixel_data_d = {win_d[0][0], win_d[0][1], win_d[0][2],
                                win_d[1][0], win_d[1][1], win_d[1][2],
                                win_d[2][0], win_d[2][1], win_d[2][2]};
                out_x_d      = cur_col - CW'(1);
                out_y_d      = cur_row - RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            pixel_data_q <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            pixel_data_q <= pixel_data_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign pixelData  = pixel_data_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_builder.sv
// tb/tb_window_builder.sv - directed self-checking bench for window_builder on an 8x6 frame
module tb_window_builder;

    localparam int W = 8;
    localparam int H = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [23:0]   in_pixel;
    logic          in_sof;
    logic          out_valid;
    logic          out_ready;
    logic [215:0]  pixelData;
    logic [2:0]    out_x;
    logic [2:0]    out_y;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;

    logic [215:0] q_win [$];
    logic [2:0]   q_x [$];
    logic [2:0]   q_y [$];
    logic [2:0]   lx = '0, ly = '0, fd_x = '0, fd_y = '0;
    int           fd_count = 0;

    window_builder #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_sof     (in_sof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pixelData  (pixelData),
        .out_x      (out_x),
        .out_y      (out_y),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Frame-done is handled first so it refers to the previously transferred window.
    always @(negedge clk) begin
        if (frame_done) begin
            fd_count++;
            fd_x = lx;
            fd_y = ly;
        end
        if (out_valid && out_ready) begin
            q_win.push_back(pixelData);
            q_x.push_back(out_x);
            q_y.push_back(out_y);
            lx = out_x;
            ly = out_y;
        end
    end

    function automatic logic [23:0] pix(input int r, input int c);
        return {8'(r), 8'(c), 8'h5A};
    endfunction

    function automatic logic [215:0] exp_win(input int x, input int y);
        logic [215:0] acc;
        acc = '0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                acc = {acc[191:0], pix(y - 1 + dy, x - 1 + dx)};
            end
        end
        return acc;
    endfunction

    task automatic chk(input string tag, input logic [215:0] obs, input logic [215:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_pixel(input logic [23:0] p, input logic sof);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_pixel = p;
        in_sof   = sof;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 216'(in_ready), 216'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input logic gap);
        for (int i = lo; i <= hi; i++) begin
            send_pixel(pix(i / W, i % W), 1'b0);
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_win.delete();
        q_x.delete();
        q_y.delete();
        fd_count = 0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_frames(input string tag, input int nframes);
        logic [215:0] w;
        logic [2:0]   cx, cy;
        chk({tag, "_count"}, 216'(q_win.size()), 216'(24 * nframes));
        for (int f = 0; f < nframes; f++) begin
            for (int y = 1; y <= H - 2; y++) begin
                for (int x = 1; x <= W - 2; x++) begin
                    if (q_win.size() > 0) begin
                        w  = q_win.pop_front();
                        cx = q_x.pop_front();
                        cy = q_y.pop_front();
                        chk({tag, "_win"}, w, exp_win(x, y));
                        chk({tag, "_xy"}, 216'({cx, cy}), 216'({3'(x), 3'(y)}));
                    end
                end
            end
        end
    endtask

    initial begin
        logic [215:0] e;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = '0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        idle(2);
        rst = 1'b0;

        chk("rst_in_ready", 216'(in_ready), 216'(1));
        chk("rst_out_valid", 216'(out_valid), 216'(0));
        chk("rst_pixelData", pixelData, 216'(0));
        chk("rst_xy", 216'({out_x, out_y}), 216'(0));
        chk("rst_frame_done", 216'(frame_done), 216'(0));

        // Full frame, consumer always ready
        clear_log();
        send_range(0, 17, 1'b0);
        chk("pre_first_valid", 216'(out_valid), 216'(0));
        send_range(18, 18, 1'b0);
        chk("first_valid", 216'(out_valid), 216'(1));
        chk("first_tl", 216'(pixelData[215:192]), 216'(24'h00005A));
        chk("first_ctr", 216'(pixelData[119:96]), 216'(24'h01015A));
        chk("first_br", 216'(pixelData[23:0]), 216'(24'h02025A));
        chk("first_xy", 216'({out_x, out_y}), 216'({3'd1, 3'd1}));
        send_range(19, W * H - 1, 1'b0);
        idle(3);
        check_frames("full", 1);
        chk("full_fd_count", 216'(fd_count), 216'(1));
        chk("full_fd_xy", 216'({fd_x, fd_y}), 216'({3'd6, 3'd4}));

        // Backpressure on window (3,2)
        clear_log();
        send_range(0, 28, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = pix(29 / W, 29 % W);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 216'(in_ready), 216'(0));
            chk("bp_hold_win", pixelData, exp_win(3, 2));
            chk("bp_hold_xy", 216'({out_valid, out_x, out_y}), 216'({1'b1, 3'd3, 3'd2}));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        send_range(29, W * H - 1, 1'b0);
        idle(3);
        check_frames("bp", 1);

        // Input gaps
        clear_log();
        send_range(0, W * H - 1, 1'b1);
        idle(3);
        check_frames("gap", 1);

        // Resync mid-frame
        pulse_reset();
        clear_log();
        send_range(0, 19, 1'b0);
        send_pixel(24'hFFFF00, 1'b1);
        send_range(1, 18, 1'b0);
        idle(3);
        chk("sof_count", 216'(q_win.size()), 216'(3));
        if (q_win.size() == 3) begin
            chk("sof_pend0", q_win[0], exp_win(1, 1));
            chk("sof_pend1", q_win[1], exp_win(2, 1));
            e = exp_win(1, 1);
            e[215:192] = 24'hFFFF00;
            chk("sof_win", q_win[2], e);
            chk("sof_xy", 216'({q_x[2], q_y[2]}), 216'({3'd1, 3'd1}));
        end

        // Reset mid-row 3
        pulse_reset();
        send_range(0, 27, 1'b0);
        pulse_reset();
        chk("mid_rst_out_valid", 216'(out_valid), 216'(0));
        chk("mid_rst_in_ready", 216'(in_ready), 216'(1));
        clear_log();
        send_range(0, W * H - 1, 1'b0);
        idle(3);
        check_frames("after_rst", 1);
        chk("after_rst_fd", 216'(fd_count), 216'(1));

        // Two back-to-back frames
        clear_log();
        send_range(0, W * H - 1, 1'b0);
        send_range(0, W * H - 1, 1'b0);
        idle(3);
        check_frames("b2b", 2);
        chk("b2b_fd_count", 216'(fd_count), 216'(2));
        chk("b2b_fd_xy", 216'({fd_x, fd_y}), 216'({3'd6, 3'd4}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
